// File: rtl/signed_acc_pkg.sv
// rtl/signed_acc_pkg.sv - shared types and limit helpers for the signed_acc slice
//
// Purpose: state encoding for the accumulator FSM plus helpers that derive the
// signed max/min and unsigned max limits of an accumulator of a given width.
// Optional feature macro (consumed by acc_sat_add): SIGNED_ACC_SAT_EN.
package signed_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Limits are built in a wide container and sliced by the user to its width.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] smax_of(input int w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] smin_of(input int w);
    return MAX_W'(1) << (w - 1);
  endfunction

  function automatic logic [MAX_W-1:0] umax_of(input int w);
    return (w >= MAX_W) ? '1 : (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

endpackage

// File: rtl/acc_sat_add.sv
// rtl/acc_sat_add.sv - combinational add with signed/unsigned overflow detect and optional clamp
//
// Purpose: sum = a + b in the mode chosen by tc; ovf flags overflow of this add.
// Ports:
//   a, b : W-bit operands (already extended to W bits by the caller)
//   tc   : 0 unsigned (carry out), 1 signed (same-sign operands, sign flip)
//   sum  : W-bit result (wrapped, or clamped when SIGNED_ACC_SAT_EN is defined)
//   ovf  : overflow of this add
// Macro: SIGNED_ACC_SAT_EN selects clamping instead of wrap-around.
module acc_sat_add
  import signed_acc_pkg::*;
#(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         tc,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0]   full;
  logic [W-1:0] raw;
  logic         s_ovf;

  assign full  = {1'b0, a} + {1'b0, b};
  assign raw   = full[W-1:0];
  assign s_ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
  assign ovf   = tc ? s_ovf : full[W];

`ifdef SIGNED_ACC_SAT_EN
  localparam logic [MAX_W-1:0] SMAX_F = smax_of(W);
  localparam logic [MAX_W-1:0] SMIN_F = smin_of(W);
  localparam logic [MAX_W-1:0] UMAX_F = umax_of(W);
  localparam logic [W-1:0]     SMAX   = SMAX_F[W-1:0];
  localparam logic [W-1:0]     SMIN   = SMIN_F[W-1:0];
  localparam logic [W-1:0]     UMAX   = UMAX_F[W-1:0];

  // Signed overflow direction follows the (shared) operand sign.
  always_comb begin
    sum = raw;
    if (ovf) begin
      if (tc) sum = a[W-1] ? SMIN : SMAX;
      else    sum = UMAX;
    end
  end
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/signed_acc.sv
// rtl/signed_acc.sv - frame multiply-accumulate back end with sticky overflow
//
// Purpose: sums len products (signed or unsigned per tc on the first beat) and
// presents the result with a sticky overflow flag on a valid/ready port.
// Ports:
//   clk, rst_n (async active-low), clr (sync abort)
//   in_vld/in_rdy, product, tc, len : product input beat and frame setup
//   out_vld/out_rdy, acc_out, ovf   : frame result
// Macro: SIGNED_ACC_SAT_EN (in acc_sat_add) clamps on overflow instead of wrapping.
module signed_acc
  import signed_acc_pkg::*;
#(
  parameter int PRODUCT_WIDTH = 16,
  parameter int ACC_WIDTH     = 24,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [PRODUCT_WIDTH-1:0] product,
  input  logic                     tc,
  input  logic [CNT_WIDTH-1:0]     len,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [ACC_WIDTH-1:0]     acc_out,
  output logic                     ovf
);

  state_e               state, state_nxt;
  logic [ACC_WIDTH-1:0] acc;
  logic                 ovf_r;
  logic [CNT_WIDTH-1:0] cnt, cnt_inc;
  logic                 tc_lat;
  logic [CNT_WIDTH-1:0] len_lat, len_eff;
  logic                 beat_in;
  logic                 tc_sel;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_ovf;

  assign in_rdy  = (state != OUT);
  assign out_vld = (state == OUT);
  assign acc_out = acc;
  assign ovf     = ovf_r;

  // A beat under clr is dropped even though in_rdy may be high.
  assign beat_in = in_vld && in_rdy && !clr;
  assign len_eff = (len == '0) ? CNT_WIDTH'(1) : len;
  assign cnt_inc = cnt + CNT_WIDTH'(1);

  // The first beat uses the live tc since tc_lat is only loaded by that beat.
  assign tc_sel = (state == IDLE) ? tc : tc_lat;
  assign ext    = tc_sel ? ACC_WIDTH'(signed'(product)) : ACC_WIDTH'(product);

  acc_sat_add #(.W(ACC_WIDTH)) u_add (
    .a   (acc),
    .b   (ext),
    .tc  (tc_lat),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (beat_in) state_nxt = (len_eff == CNT_WIDTH'(1)) ? OUT : ACC;
        ACC:     if (beat_in && cnt_inc == len_lat) state_nxt = OUT;
        OUT:     if (out_rdy) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      ovf_r   <= 1'b0;
      cnt     <= '0;
      tc_lat  <= 1'b0;
      len_lat <= '0;
    end else if (clr) begin
      acc   <= '0;
      ovf_r <= 1'b0;
      cnt   <= '0;
    end else if (beat_in) begin
      if (state == IDLE) begin
        tc_lat  <= tc;
        len_lat <= len_eff;
        acc     <= ext;
        ovf_r   <= 1'b0;
        cnt     <= CNT_WIDTH'(1);
      end else begin
        acc   <= add_sum;
        ovf_r <= ovf_r | add_ovf;
        cnt   <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_signed_acc.sv
// tb/tb_signed_acc.sv - directed self-checking bench for signed_acc (24-bit and 18-bit accumulators)
module tb_signed_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_vld = 1'b0;
  logic        out_rdy = 1'b0;
  logic        tc = 1'b0;
  logic [15:0] product = '0;
  logic [7:0]  len = '0;

  logic        in_rdy0, out_vld0, ovf0;
  logic [23:0] acc_out0;
  logic        in_rdy1, out_vld1, ovf1;
  logic [17:0] acc_out1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  signed_acc #(.PRODUCT_WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(8)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_rdy(in_rdy0),
    .product(product), .tc(tc), .len(len), .out_vld(out_vld0), .out_rdy(out_rdy),
    .acc_out(acc_out0), .ovf(ovf0)
  );

  signed_acc #(.PRODUCT_WIDTH(16), .ACC_WIDTH(18), .CNT_WIDTH(8)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_rdy(in_rdy1),
    .product(product), .tc(tc), .len(len), .out_vld(out_vld1), .out_rdy(out_rdy),
    .acc_out(acc_out1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] p, input logic t, input logic [7:0] l);
    product = p;
    tc      = t;
    len     = l;
    in_vld  = 1'b1;
    cyc();
    in_vld  = 1'b0;
  endtask

  task automatic take();
    out_rdy = 1'b1;
    cyc();
    out_rdy = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) cyc();
    chk("rst_out_vld", 32'(out_vld0), 32'h0);
    chk("rst_acc_out", 32'(acc_out0), 32'h0);
    chk("rst_ovf", 32'(ovf0), 32'h0);
    rst_n = 1'b1;
    cyc();
    chk("rst_in_rdy", 32'(in_rdy0), 32'h1);

    // Signed frame of three
    beat(16'hFFF0, 1'b1, 8'd3);
    beat(16'h0020, 1'b0, 8'd0);
    chk("t1_vld_early", 32'(out_vld0), 32'h0);
    beat(16'hFFFF, 1'b0, 8'd0);
    chk("t1_vld", 32'(out_vld0), 32'h1);
    chk("t1_acc", 32'(acc_out0), 32'h00000F);
    chk("t1_ovf", 32'(ovf0), 32'h0);
    take();
    chk("t1_vld_after", 32'(out_vld0), 32'h0);

    // Same products unsigned
    beat(16'hFFF0, 1'b0, 8'd3);
    beat(16'h0020, 1'b1, 8'd0);
    beat(16'hFFFF, 1'b1, 8'd0);
    chk("t2_acc", 32'(acc_out0), 32'h02000F);
    chk("t2_ovf", 32'(ovf0), 32'h0);
    take();

    // len=0 and len=1 single beats
    beat(16'h8000, 1'b1, 8'd0);
    chk("t3_len0_vld", 32'(out_vld0), 32'h1);
    chk("t3_len0_acc", 32'(acc_out0), 32'hFF8000);
    take();
    beat(16'h8000, 1'b1, 8'd1);
    chk("t3_len1_vld", 32'(out_vld0), 32'h1);
    chk("t3_len1_acc", 32'(acc_out0), 32'hFF8000);
    take();

    // Signed overflow on the 18-bit instance
    beat(16'h7FFF, 1'b1, 8'd5);
    repeat (4) beat(16'h7FFF, 1'b1, 8'd0);
    chk("t4_vld18", 32'(out_vld1), 32'h1);
`ifdef SIGNED_ACC_SAT_EN
    chk("t4_acc18", 32'(acc_out1), 32'h1FFFF);
`else
    chk("t4_acc18", 32'(acc_out1), 32'h27FFB);
`endif
    chk("t4_ovf18", 32'(ovf1), 32'h1);
    chk("t4_acc24", 32'(acc_out0), 32'h027FFB);
    chk("t4_ovf24", 32'(ovf0), 32'h0);
    take();

    // Unsigned overflow on the 18-bit instance
    beat(16'hFFFF, 1'b0, 8'd5);
    repeat (4) beat(16'hFFFF, 1'b0, 8'd0);
`ifdef SIGNED_ACC_SAT_EN
    chk("t4u_acc18", 32'(acc_out1), 32'h3FFFF);
`else
    chk("t4u_acc18", 32'(acc_out1), 32'h0FFFB);
`endif
    chk("t4u_ovf18", 32'(ovf1), 32'h1);
    take();

    // Backpressure with in_vld held high in OUT
    beat(16'h0003, 1'b0, 8'd2);
    beat(16'h0004, 1'b0, 8'd0);
    product = 16'h0100;
    tc      = 1'b0;
    len     = 8'd1;
    in_vld  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_hold_vld", 32'(out_vld0), 32'h1);
      chk("t5_hold_acc", 32'(acc_out0), 32'h7);
      chk("t5_hold_rdy", 32'(in_rdy0), 32'h0);
      cyc();
    end
    out_rdy = 1'b1;
    cyc();
    out_rdy = 1'b0;
    chk("t5_hs_vld", 32'(out_vld0), 32'h0);
    chk("t5_hs_rdy", 32'(in_rdy0), 32'h1);
    cyc();
    in_vld = 1'b0;
    chk("t5_next_vld", 32'(out_vld0), 32'h1);
    chk("t5_next_acc", 32'(acc_out0), 32'h100);
    take();

    // clr after two of four beats
    beat(16'h0001, 1'b0, 8'd4);
    beat(16'h0002, 1'b0, 8'd0);
    clr     = 1'b1;
    in_vld  = 1'b1;
    product = 16'h0009;
    cyc();
    clr    = 1'b0;
    in_vld = 1'b0;
    chk("t6_clr_vld", 32'(out_vld0), 32'h0);
    chk("t6_clr_acc", 32'(acc_out0), 32'h0);
    cyc();
    chk("t6_clr_vld2", 32'(out_vld0), 32'h0);
    beat(16'h0005, 1'b1, 8'd1);
    chk("t6_after_vld", 32'(out_vld0), 32'h1);
    chk("t6_after_acc", 32'(acc_out0), 32'h000005);
    take();

    // Asynchronous reset mid-frame
    beat(16'h0007, 1'b0, 8'd4);
    beat(16'h0007, 1'b0, 8'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_acc", 32'(acc_out0), 32'h0);
    chk("t6_rst_vld", 32'(out_vld0), 32'h0);
    chk("t6_rst_ovf", 32'(ovf0), 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    beat(16'h0006, 1'b0, 8'd1);
    chk("t6_post_rst_acc", 32'(acc_out0), 32'h000006);
    take();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/signed_acc.md
Name: signed_acc

Overview:
- Sequential multiply-accumulate back end that sits directly downstream of the combinational signed/unsigned multiplier.
- Consumes one product per valid/ready beat and sums a frame of `len` products in the mode selected by `tc`.
- Presents the frame result, with a sticky overflow flag, on a valid/ready output port.

Parameters:
- PRODUCT_WIDTH, 16, width of incoming product (matches multiplier A_WIDTH+B_WIDTH)
- ACC_WIDTH, 24, accumulator/result width; must be >= PRODUCT_WIDTH
- CNT_WIDTH, 8, width of frame-length field and beat counter

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous abort; discards the current frame
- in_vld  input  1  product valid
- in_rdy  output  1  block can accept a product
- product  input  PRODUCT_WIDTH  multiplier result
- tc  input  1  0 unsigned, 1 signed; sampled on the first beat of a frame only
- len  input  CNT_WIDTH  products per frame; sampled on the first beat; 0 is treated as 1
- out_vld  output  1  result valid
- out_rdy  input  1  downstream accepts result
- acc_out  output  ACC_WIDTH  frame sum
- ovf  output  1  overflow occurred during the frame (sticky within the frame)

Behaviour:
- **Clock and reset:**
  - One clock, clk.
  - rst_n is asynchronous, active-low.
  - On reset: state=IDLE, acc_out=0, ovf=0, out_vld=0, beat count=0, latched tc/len=0.
  - in_rdy is combinational: in_rdy = (state != OUT), so it is 1 once reset deasserts.
- **Beat acceptance:** a beat is accepted when in_vld && in_rdy. out handshake = out_vld && out_rdy.
- **Product extension:** tc_lat=1 sign-extends product to ACC_WIDTH; tc_lat=0 zero-extends.
- **IDLE:**
  - On accept: latch tc and len (len_lat = max(len,1)), acc <= ext(product), ovf <= 0, cnt <= 1.
  - If len_lat==1, go to OUT; else go to ACC.
- **ACC:**
  - On accept: acc <= acc + ext(product), cnt <= cnt+1, ovf |= overflow of this add.
  - When cnt+1 == len_lat, go to OUT.
  - tc/len inputs are ignored in ACC.
  - Idle cycles (in_vld=0) hold all state.
- **OUT:**
  - out_vld=1; acc_out and ovf stay stable until the out handshake; in_vld is ignored.
  - On handshake, return to IDLE; out_vld=0 next cycle.
  - No new beat is accepted in the handshake cycle (in_rdy=0 in OUT).
- **Latency:** out_vld rises in the cycle after the last beat is accepted. Throughput is len_lat beats + 1 result cycle minimum per frame.
- **Overflow detection:**
  - tc_lat=0: carry out of bit ACC_WIDTH-1.
  - tc_lat=1: both operands have the same sign and the result sign differs.
  - Without the saturation option, acc wraps modulo 2^ACC_WIDTH.
- **clr:**
  - Highest synchronous priority, in any state: state <= IDLE, out_vld <= 0, acc <= 0, ovf <= 0, cnt <= 0.
  - A beat presented with clr=1 is not accumulated (in_rdy remains per state, but the beat is dropped).
- **Reset mid-frame:** all state is discarded immediately; no partial result is emitted.
- acc_out is a registered output, and the accumulator register itself; it is valid only while out_vld=1.

Optional Feature:
- Macro: SIGNED_ACC_SAT_EN.
- Defined: on overflow the sum is clamped.
  - tc_lat=1: clamp to 0 1..1 (positive max) or 1 0..0 (negative min) per the overflow direction.
  - tc_lat=0: clamp to all ones.
  - Saturation persists: later adds continue from the clamped value. ovf is still set.
- Undefined: wrap-around arithmetic, and no saturation logic is synthesised.

Decomposition:
- Package signed_acc_pkg holds:
  - state enum (IDLE=2'd0, ACC=2'd1, OUT=2'd2);
  - localparams for signed max/min and unsigned max, derived from ACC_WIDTH.
- One combinational sub-module, acc_sat_add:
  - inputs a, b, tc; outputs sum, ovf;
  - contains the extension-agnostic add, overflow detect and the SIGNED_ACC_SAT_EN clamp.

Test Plan:
1. Defaults; tc=1, len=3, products 0xFFF0, 0x0020, 0xFFFF -> acc_out=0x00000F, ovf=0, out_vld one cycle after the third accept.
2. Same products with tc=0 -> acc_out=0x02000F, ovf=0.
3. len=0 then len=1, single beat 0x8000, tc=1 -> each frame gives acc_out=0xFF8000 with out_vld on the next cycle; len=0 behaves identically to len=1.
4. ACC_WIDTH=18; tc=1, len=5, product 0x7FFF each -> wrap build: acc_out=0x27FFB, ovf=1; SIGNED_ACC_SAT_EN build: acc_out=0x1FFFF, ovf=1.
5. Backpressure: out_rdy=0 for 4 cycles in OUT with in_vld=1 -> out_vld=1, acc_out stable, in_rdy=0, no beat consumed; out_rdy=1 -> IDLE next cycle, then the next beat is accepted as a new frame.
6. Aborts:
   - clr asserted after 2 of 4 beats -> out_vld stays 0; a following frame tc=1, len=1, 0x0005 -> acc_out=0x000005.
   - rst_n pulsed low mid-frame -> outputs are 0 asynchronously.
